// File: rtl/conv3x3_engine.sv
// Purpose : sweeps a 3x3 window over three buffered padded rows, convolves, shifts, clamps to 8 bits.
// Latency : 3 cycles from window issue to o_valid; one output pixel per cycle when unstalled.
// Backpres: o_valid & ~i_ready freezes the whole pipeline and the column counter; no beat lost.
// Ports   : i_pixel_buffer/i_kernel/i_norm_shift in, i_start kicks one row, i_ready from downstream;
//           o_pixel/o_valid/o_addr stream out, o_busy, o_row_done and o_frame_done pulses.
module conv3x3_engine #(
    parameter int PIXEL_WIDTH     = 8,
    parameter int ADDR_WIDTH      = 18,
    parameter int ZP_IMAGE_WIDTH  = 482,
    parameter int ZP_IMAGE_HEIGHT = 362,
    parameter int BUFFER_WIDTH    = 3,
    parameter int COEF_WIDTH      = 8,
    parameter int OUT_WIDTH       = ZP_IMAGE_WIDTH - 2,
    parameter int OUT_HEIGHT      = ZP_IMAGE_HEIGHT - 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [PIXEL_WIDTH-1:0]       i_pixel_buffer [0:BUFFER_WIDTH-1][0:ZP_IMAGE_WIDTH-1],
    input  logic                         i_start,
    input  logic signed [COEF_WIDTH-1:0] i_kernel [0:8],
    input  logic [3:0]                   i_norm_shift,
    input  logic                         i_ready,
    output logic [PIXEL_WIDTH-1:0]       o_pixel,
    output logic                         o_valid,
    output logic [ADDR_WIDTH-1:0]        o_addr,
    output logic                         o_busy,
    output logic                         o_row_done,
    output logic                         o_frame_done
);

    localparam int COL_W  = $clog2(OUT_WIDTH);
    localparam int ROW_W  = $clog2(OUT_HEIGHT);
    localparam int IDX_W  = $clog2(ZP_IMAGE_WIDTH);
    localparam int PROD_W = PIXEL_WIDTH + 1 + COEF_WIDTH;
    localparam int SUM_W  = PROD_W + 4;
    localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'((1 << PIXEL_WIDTH) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                       state, state_nxt;
    logic [COL_W-1:0]             col;
    logic [ROW_W-1:0]             row;
    logic signed [COEF_WIDTH-1:0] kern_q [0:8];
    logic [3:0]                   shift_q;

    logic                         s1_vld, s2_vld;
    logic [COL_W-1:0]             s1_col, s2_col;
    logic [PIXEL_WIDTH-1:0]       s1_win [0:8];
    logic signed [PROD_W-1:0]     s2_prod [0:8];

    logic                         stall, adv, issue, last_col, pipe_empty;
    logic [PIXEL_WIDTH-1:0]       win_c [0:8];
    logic signed [PROD_W-1:0]     prod_c [0:8];
    logic signed [SUM_W-1:0]      sum_c, shifted_c;
    logic [PIXEL_WIDTH-1:0]       pix_c;
    logic [ADDR_WIDTH-1:0]        addr_c;

    assign stall      = o_valid & ~i_ready;
    assign adv        = ~stall;
    assign last_col   = (col == COL_W'(OUT_WIDTH - 1));
    // o_valid is part of "empty": the row is only done once the final beat has left.
    assign pipe_empty = ~s1_vld & ~s2_vld & ~o_valid;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start)          state_nxt = RUN;
            RUN:     if (issue && last_col) state_nxt = DRAIN;
            DRAIN:   if (pipe_empty)       state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_busy       = (state != IDLE);
        issue        = (state == RUN) && adv;
        o_row_done   = (state == DRAIN) && pipe_empty;
        o_frame_done = o_row_done && (row == ROW_W'(OUT_HEIGHT - 1));
    end

    // Column/row counters and the per-row coefficient snapshot
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col     <= '0;
            row     <= '0;
            shift_q <= '0;
            for (int k = 0; k < 9; k++) kern_q[k] <= '0;
        end else begin
            if (state == IDLE && i_start) begin
                col     <= '0;
                shift_q <= i_norm_shift;
                for (int k = 0; k < 9; k++) kern_q[k] <= i_kernel[k];
            end else if (issue && !last_col) begin
                col <= col + 1'b1;
            end
            if (o_row_done)
                row <= (row == ROW_W'(OUT_HEIGHT - 1)) ? '0 : row + 1'b1;
        end
    end

    // Datapath: window select, products, sum/shift/clamp, address
    always_comb begin
        for (int r = 0; r < 3; r++)
            for (int j = 0; j < 3; j++)
                win_c[3*r + j] = i_pixel_buffer[r][IDX_W'(col) + IDX_W'(j)];
        // Pixels are unsigned: a zero MSB makes them non-negative signed operands.
        for (int k = 0; k < 9; k++)
            prod_c[k] = PROD_W'(signed'({1'b0, s1_win[k]})) * PROD_W'(kern_q[k]);
        sum_c = '0;
        for (int k = 0; k < 9; k++)
            sum_c = sum_c + {{(SUM_W-PROD_W){s2_prod[k][PROD_W-1]}}, s2_prod[k]};
        shifted_c = sum_c >>> shift_q;
        if (shifted_c < 0)             pix_c = '0;
        else if (shifted_c > PIX_MAX)  pix_c = '1;
        else                           pix_c = shifted_c[PIXEL_WIDTH-1:0];
        addr_c = ADDR_WIDTH'(row) * ADDR_WIDTH'(OUT_WIDTH) + ADDR_WIDTH'(s2_col);
    end

    // Three-stage pipeline; every stage holds while the output beat is stalled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            s1_col  <= '0;
            s2_col  <= '0;
            o_valid <= 1'b0;
            o_pixel <= '0;
            o_addr  <= '0;
            for (int k = 0; k < 9; k++) begin
                s1_win[k]  <= '0;
                s2_prod[k] <= '0;
            end
        end else if (adv) begin
            s1_vld  <= issue;
            s1_col  <= col;
            s2_vld  <= s1_vld;
            s2_col  <= s1_col;
            o_valid <= s2_vld;
            for (int k = 0; k < 9; k++) begin
                s1_win[k]  <= win_c[k];
                s2_prod[k] <= prod_c[k];
            end
            if (s2_vld) begin
                o_pixel <= pix_c;
                o_addr  <= addr_c;
            end
        end
    end

endmodule

// File: doc/conv3x3_engine.md
Name: conv3x3_engine

Overview:
- Downstream consumer of the 3-row zero-padded line buffer. Once the buffer holds three valid rows, this block sweeps a 3x3 window across them.
- For each window it computes a signed 3x3 convolution, normalises and clamps the result to 8 bits, and streams one output pixel per cycle with a valid/ready handshake and a linear output address.
- It pulses o_row_done so the buffer controller can shift in the next row, and pulses o_frame_done after the last output row.

Parameters:
- PIXEL_WIDTH, 8, pixel bit width (unsigned)
- ADDR_WIDTH, 18, output address width
- ZP_IMAGE_WIDTH, 482, padded row width
- ZP_IMAGE_HEIGHT, 362, padded image height
- BUFFER_WIDTH, 3, rows in window/buffer
- COEF_WIDTH, 8, signed kernel coefficient width
- OUT_WIDTH, ZP_IMAGE_WIDTH-2, output pixels per row (480)
- OUT_HEIGHT, ZP_IMAGE_HEIGHT-2, output rows per frame (360)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_pixel_buffer  in  PIXEL_WIDTH x [0:BUFFER_WIDTH-1][0:ZP_IMAGE_WIDTH-1]  buffered rows; row 0 = top
- i_start  in  1  buffer rows valid, begin one output row
- i_kernel  in  COEF_WIDTH x [0:8]  signed coefficients, row-major, index 4 = centre
- i_norm_shift  in  4  arithmetic right-shift applied to the sum
- i_ready  in  1  downstream accepts o_pixel
- o_pixel  out  PIXEL_WIDTH  clamped result
- o_valid  out  1  o_pixel/o_addr valid
- o_addr  out  ADDR_WIDTH  row*OUT_WIDTH + col
- o_busy  out  1  high in any state other than IDLE
- o_row_done  out  1  one-cycle pulse, row fully accepted downstream
- o_frame_done  out  1  one-cycle pulse together with o_row_done of row OUT_HEIGHT-1

Behaviour:
- Reset: state=IDLE; column and row counters 0; pipeline valid bits 0; o_pixel=0, o_valid=0, o_addr=0, o_busy=0, o_row_done=0, o_frame_done=0. Reset mid-row aborts the row immediately; no pulses are emitted.
- FSM states:
  - IDLE: i_start=1 -> RUN, col=0. i_kernel and i_norm_shift are latched on this edge; later changes have no effect until the next start.
  - RUN: issues window col each unstalled cycle. Issuing col=OUT_WIDTH-1 -> DRAIN.
  - DRAIN: waits until all pipeline stages are empty and the last beat has been accepted -> IDLE, with o_row_done pulsed that cycle.
  - i_start is ignored outside IDLE.
- Window for col c: rows 0..2, columns c..c+2; k = 3*r + (j-c).
- Pipeline (3 stages, latency 3 cycles issue->o_valid):
  - S1: register the 9 window pixels.
  - S2: 9 products; each pixel is zero-extended to signed and multiplied by its coefficient, giving a 17-bit signed product.
  - S3: sum into 21-bit signed, arithmetic shift right by the latched shift, clamp (<0 -> 0, >255 -> 255), then register o_pixel/o_valid/o_addr.
- Stall: when o_valid=1 and i_ready=0, the entire pipeline and the column counter freeze; o_pixel and o_addr stay stable. No beat is dropped or duplicated. Exactly OUT_WIDTH handshakes occur per row.
- When o_valid=0, i_ready is don't-care.
- Row counter increments on o_row_done. At row OUT_HEIGHT-1, o_frame_done pulses together with o_row_done, and the row counter wraps to 0.
- o_addr = row*OUT_WIDTH + col, range 0..172799.

Test Plan:
- Identity kernel (k4=1, others 0), shift 0, buffer[1][j]=j mod 256, i_ready=1 -> 480 beats; beat c has o_pixel=(c+1) mod 256 and o_addr=c; first o_valid 3 cycles after i_start; o_row_done follows the final beat.
- All coefficients 1, shift 3, all pixels 16 -> every o_pixel=18 (144>>3).
- Clamping:
  - k4=-1, pixels 50 -> o_pixel=0.
  - All coefficients 8, shift 0, pixels 255 -> o_pixel=255.
- Backpressure: drop i_ready for 5 cycles at beat 100 -> o_pixel/o_addr held at beat 100; total accepted beats=480; o_addr sequence contiguous.
- Frame: 360 i_start pulses, each issued after the previous o_row_done -> o_frame_done only on the 360th o_row_done; last o_addr=172799; next row restarts o_addr at 0.
- Robustness:
  - Assert i_rst at beat 200 -> all outputs 0 next edge, no o_row_done; a fresh i_start produces o_addr 0..479.
  - An i_start asserted during RUN is ignored.
